lcd_hex_display: RTL
====================

Name: lcd_hex_display

Overview:
- Downstream consumer of the MiniAlu LED byte. It drives the Spartan-3E 2x16 character LCD through the 4-bit interface.
- After reset it runs the HD44780 power-on and configuration sequence.
- On each iValid strobe it shows the byte as two ASCII hex characters at line 1, column 0. The strobe is the cycle the ALU's LED register loads.

Parameters:
- P_T_POWERON, 750000, idle cycles after reset before the first write (15 ms at 50 MHz).
- P_T_INIT1, 205000, wait after init nibble 1 (4.1 ms).
- P_T_INIT2, 5000, wait after init nibble 2 (100 us).
- P_T_SHORT, 2000, wait after init nibbles 3 and 4 and after every full byte except Clear (40 us).
- P_T_CLEAR, 82000, wait after the Clear command (1.64 ms).
- P_T_GAP, 50, wait between the upper and lower nibble of one byte (1 us).
- P_T_E, 12, oLCD_E high width in cycles (240 ns).

Ports:
- Clock  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high
- iData  in  8  byte to display
- iValid  in  1  single-cycle strobe; samples iData
- oReady  out  1  high when idle, init done and no pending update
- oLCD_E  out  1  LCD enable
- oLCD_RS  out  1  0 = command, 1 = data
- oLCD_RW  out  1  constant 0
- oLCD_D  out  4  LCD data nibble (SF_D[11:8])

Behaviour:
- Reset: async and immediate.
  - oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_D=0, oReady=0.
  - Pending flag and latched data cleared; FSM goes to ST_POWERON and the wait counter reloads.
- Nibble write, 2+P_T_E+2 cycles total:
  - RS and D driven stable for 2 cycles.
  - E high for exactly P_T_E cycles.
  - RS and D held for 2 cycles after E falls.
  - The post-nibble wait follows. E is never high during any wait.
- Byte write: upper nibble, then P_T_GAP wait, then lower nibble, then P_T_SHORT wait (P_T_CLEAR for command 0x01).
- FSM states: ST_POWERON, ST_INIT, ST_CFG, ST_IDLE, ST_ADDR, ST_CHAR_HI, ST_CHAR_LO.
  - ST_POWERON: wait P_T_POWERON, then go to ST_INIT.
  - ST_INIT: four single-nibble writes, RS=0.
    - 0x3, wait P_T_INIT1.
    - 0x3, wait P_T_INIT2.
    - 0x3, wait P_T_SHORT.
    - 0x2, wait P_T_SHORT.
  - ST_CFG: byte writes, RS=0: 0x28, 0x06, 0x0C, 0x01. Then go to ST_IDLE.
  - ST_IDLE: oReady=1. On iValid, latch iData, drop oReady the next cycle, go to ST_ADDR.
  - ST_ADDR: write byte 0x80, RS=0.
  - ST_CHAR_HI: write ASCII of iData[7:4], RS=1.
  - ST_CHAR_LO: write ASCII of iData[3:0], RS=1. Then return to ST_IDLE, or to ST_ADDR if an update is pending.
- Hex to ASCII: nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x37+n (0x41-0x46).
- Latency: with default params, iValid in ST_IDLE to oReady high is 3 x (16+P_T_GAP+16+P_T_SHORT) + 1 cycles.
- iValid outside ST_IDLE, including during init:
  - The data goes into a pending register and sets the pending flag.
  - Newest value wins; at most one pending update is held.
  - The pending update starts after the current sequence completes, or after init completes.
- iValid in the same cycle the FSM returns to ST_IDLE: treated as an idle strobe and taken directly.
- The update shown is the value latched at the start of the update; iData changes mid-update have no effect.
- Counters: wide enough for the largest wait parameter, minimum 20 bits. Waits are exact: N cycles, no off-by-one.

Decomposition:
- Shared package lcd_defs: command constants (CMD_FUNC_SET 0x28, CMD_ENTRY 0x06, CMD_DISP_ON 0x0C, CMD_CLEAR 0x01, CMD_DDRAM0 0x80), FSM state encodings, setup/hold constant 2.
- Sub-module lcd_nibble_writer:
  - Inputs: Clock, Reset, iStart, iRS, iNibble, iWait.
  - Outputs: oLCD_E, oLCD_RS, oLCD_D, oDone.
  - Generates one setup/E/hold sequence followed by iWait idle cycles, then pulses oDone for one cycle.
- The top level sequences nibbles and does ASCII conversion.

Test Plan (bench params: POWERON=100, INIT1=40, INIT2=20, SHORT=10, CLEAR=30, GAP=4, E=3; log (RS, D) at each E fall):
- Reset release, no iValid -> first E rise ≥ 102 cycles after release. RS=0 nibbles 3,3,3,2,2,8,0,6,0,C,0,1. oReady rises after the Clear wait.
- iData=0x5A, iValid while idle -> (0,8),(0,0),(1,3),(1,5),(1,4),(1,1). oReady low 1 cycle after iValid, back high after the final SHORT wait.
- 0x00 then 0xFF, sequential -> data nibbles 3,0,3,0, then 4,6,4,6.
- 0x12 strobed while idle, then 0x34 and 0x56 strobed during the 0x12 update -> exactly two updates, showing '12' then '56'. 0x34 never appears.
- iValid=0x9C during ST_INIT -> after Clear, the update runs immediately showing '9','C' (nibbles 3,9,4,3). oReady stays low throughout.
- Reset asserted while oLCD_E=1 mid-character -> E, RS and D go to 0 in the same cycle. Pending flag is cleared. The full init sequence repeats, and oLCD_RW stays 0 throughout.
- Every E pulse -> exactly 3 cycles high, with RS and D stable 2 cycles before the rise and 2 cycles after the fall.

Source files
------------

// File: rtl/lcd_hex_display_pkg.sv
// rtl/lcd_hex_display_pkg.sv - shared LCD command constants, FSM encodings and helpers
package lcd_defs;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_DDRAM0   = 8'h80;

  localparam int SETUP_HOLD = 2;

  typedef enum logic [2:0] {
    ST_POWERON, ST_INIT, ST_CFG, ST_IDLE, ST_ADDR, ST_CHAR_HI, ST_CHAR_LO
  } state_e;

  typedef enum logic [2:0] {
    WR_IDLE, WR_SETUP, WR_EHI, WR_HOLD, WR_WAIT
  } wr_phase_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// rtl/lcd_nibble_writer.sv - one setup/E/hold nibble cycle followed by a programmable idle wait
module lcd_nibble_writer
  import lcd_defs::*;
#(
  parameter int CW    = 20,
  parameter int P_T_E = 12
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iStart,
  input  logic          iRS,
  input  logic [3:0]    iNibble,
  input  logic [CW-1:0] iWait,
  output logic          oLCD_E,
  output logic          oLCD_RS,
  output logic [3:0]    oLCD_D,
  output logic          oDone
);

  wr_phase_e     phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          rs_q, rs_d;
  logic [3:0]    nib_q, nib_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase_q <= WR_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
    end
  end

  // oDone fires in the last idle cycle so a new start can follow with no gap
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    rs_d    = rs_q;
    nib_d   = nib_q;
    oDone   = 1'b0;
    case (phase_q)
      WR_SETUP: begin
        if (cnt_q == '0) begin
          phase_d = WR_EHI;
          cnt_d   = CW'(P_T_E - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR_EHI: begin
        if (cnt_q == '0) begin
          phase_d = WR_HOLD;
          cnt_d   = CW'(SETUP_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (wait_q == '0) begin
          oDone   = 1'b1;
          phase_d = WR_IDLE;
        end else begin
          phase_d = WR_WAIT;
          cnt_d   = wait_q - CW'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          oDone   = 1'b1;
          phase_d = WR_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
    if (iStart) begin
      phase_d = WR_SETUP;
      cnt_d   = CW'(SETUP_HOLD - 1);
      rs_d    = iRS;
      nib_d   = iNibble;
      wait_d  = iWait;
    end
  end

  assign oLCD_E  = (phase_q == WR_EHI);
  assign oLCD_RS = rs_q;
  assign oLCD_D  = nib_q;

endmodule

// File: rtl/lcd_hex_display.sv
// rtl/lcd_hex_display.sv - HD44780 init plus two-digit hex display of an incoming byte
module lcd_hex_display
  import lcd_defs::*;
#(
  parameter int P_T_POWERON = 750000,
  parameter int P_T_INIT1   = 205000,
  parameter int P_T_INIT2   = 5000,
  parameter int P_T_SHORT   = 2000,
  parameter int P_T_CLEAR   = 82000,
  parameter int P_T_GAP     = 50,
  parameter int P_T_E       = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_D
);

  localparam int MAXW = max2(max2(max2(P_T_POWERON, P_T_INIT1), max2(P_T_INIT2, P_T_SHORT)),
                             max2(max2(P_T_CLEAR, P_T_GAP), P_T_E));
  localparam int CW   = max2($clog2(MAXW + 1), 20);

  state_e        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic          busy_q, busy_d;
  logic [7:0]    data_q, data_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic [CW-1:0] pwr_cnt_q, pwr_cnt_d;

  logic          wr_start, wr_rs, wr_done, last;
  logic [3:0]    wr_nib;
  logic [CW-1:0] wr_wait;
  logic [7:0]    cur_byte;
  state_e        next_st;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_POWERON;
      step_q      <= 3'd0;
      busy_q      <= 1'b0;
      data_q      <= 8'h00;
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
      pwr_cnt_q   <= CW'(P_T_POWERON - 1);
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pwr_cnt_q   <= pwr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pwr_cnt_d   = pwr_cnt_q;
    wr_start    = 1'b0;
    wr_rs       = 1'b0;
    wr_nib      = 4'h0;
    wr_wait     = '0;
    cur_byte    = 8'h00;
    last        = step_q[0];
    next_st     = state_q;

    case (state_q)
      ST_CFG: begin
        case (step_q[2:1])
          2'd0:    cur_byte = CMD_FUNC_SET;
          2'd1:    cur_byte = CMD_ENTRY;
          2'd2:    cur_byte = CMD_DISP_ON;
          default: cur_byte = CMD_CLEAR;
        endcase
        last    = (step_q == 3'd7);
        next_st = ST_IDLE;
      end
      ST_ADDR: begin
        cur_byte = CMD_DDRAM0;
        next_st  = ST_CHAR_HI;
      end
      ST_CHAR_HI: begin
        wr_rs    = 1'b1;
        cur_byte = hex_ascii(data_q[7:4]);
        next_st  = ST_CHAR_LO;
      end
      ST_CHAR_LO: begin
        wr_rs    = 1'b1;
        cur_byte = hex_ascii(data_q[3:0]);
        next_st  = ST_IDLE;
      end
      default: ;
    endcase

    // Byte writes: upper nibble then GAP, lower nibble then SHORT (CLEAR for the Clear command)
    wr_nib = step_q[0] ? cur_byte[3:0] : cur_byte[7:4];
    if (!step_q[0]) begin
      wr_wait = CW'(P_T_GAP);
    end else if (!wr_rs && cur_byte == CMD_CLEAR) begin
      wr_wait = CW'(P_T_CLEAR);
    end else begin
      wr_wait = CW'(P_T_SHORT);
    end

    if (state_q == ST_INIT) begin
      wr_nib  = (step_q == 3'd3) ? 4'h2 : 4'h3;
      case (step_q)
        3'd0:    wr_wait = CW'(P_T_INIT1);
        3'd1:    wr_wait = CW'(P_T_INIT2);
        default: wr_wait = CW'(P_T_SHORT);
      endcase
      last    = (step_q == 3'd3);
      next_st = ST_CFG;
    end

    if (state_q == ST_POWERON) begin
      step_d = 3'd0;
      if (pwr_cnt_q == '0) begin
        state_d = ST_INIT;
      end else begin
        pwr_cnt_d = pwr_cnt_q - CW'(1);
      end
    end else if (state_q != ST_IDLE && (!busy_q || wr_done)) begin
      wr_start = 1'b1;
      if (last) begin
        state_d = next_st;
        step_d  = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end

    // ST_IDLE is entered while the last nibble drains; it only accepts once the writer is free
    if (state_q == ST_IDLE && !busy_q) begin
      if (iValid || pend_q) begin
        data_d  = iValid ? iData : pend_data_q;
        pend_d  = 1'b0;
        state_d = ST_ADDR;
        step_d  = 3'd0;
      end
    end else if (iValid) begin
      pend_data_d = iData;
      pend_d      = 1'b1;
    end

    busy_d = wr_start ? 1'b1 : (wr_done ? 1'b0 : busy_q);
  end

  lcd_nibble_writer #(
    .CW    (CW),
    .P_T_E (P_T_E)
  ) u_writer (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (wr_start),
    .iRS     (wr_rs),
    .iNibble (wr_nib),
    .iWait   (wr_wait),
    .oLCD_E  (oLCD_E),
    .oLCD_RS (oLCD_RS),
    .oLCD_D  (oLCD_D),
    .oDone   (wr_done)
  );

  assign oReady  = (state_q == ST_IDLE) && !busy_q && !pend_q;
  assign oLCD_RW = 1'b0;

endmodule
